// File: rtl/pio_edge_poller_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// pio_edge_poller_if : PIO register bus (Avalon-MM) plus event-record stream
// Rev 1.0
// ============================================================================
interface pio_edge_poller_if #(
  parameter int DATA_W = 8,
  parameter int TS_W   = 32
);
  logic [1:0]        pio_address;
  logic              pio_chipselect;
  logic              pio_write_n;
  logic [31:0]       pio_writedata;
  logic [31:0]       pio_readdata;

  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_edges;
  logic [DATA_W-1:0] evt_level;
  logic [TS_W-1:0]   evt_timestamp;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  pio_readdata,
    output evt_valid, evt_edges, evt_level, evt_timestamp,
    input  evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output pio_readdata,
    input  evt_valid, evt_edges, evt_level, evt_timestamp,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/pio_edge_poller.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// pio_edge_poller : polls an edge-capture PIO, clears captured bits, emits events
// Rev 1.0
// ============================================================================
module pio_edge_poller #(
  parameter int DATA_W      = 8,
  parameter int POLL_PERIOD = 1024,
  parameter int TS_W        = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable_i,
  pio_edge_poller_if.master   bus,
  output logic                busy_o,
  output logic [15:0]         missed_polls_o
);

  localparam int              TMR_W      = $clog2(POLL_PERIOD);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_PERIOD - 1);
  localparam logic [1:0]      ADDR_LEVEL = 2'd0;
  localparam logic [1:0]      ADDR_EDGE  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_CAP   = 3'd1,
    S_CAP_WAIT = 3'd2,
    S_RD_LVL   = 3'd3,
    S_LVL_WAIT = 3'd4,
    S_CLR      = 3'd5,
    S_EMIT     = 3'd6
  } state_t;

  state_t            state_q;
  logic [TS_W-1:0]   ts_q;
  logic [TMR_W-1:0]  timer_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] lvl_q;
  logic [TS_W-1:0]   ts_cap_q;
  logic [15:0]       missed_q;
  logic              busy_q;

  logic [1:0]        pio_addr_q;
  logic              pio_cs_q;
  logic              pio_wr_n_q;
  logic [31:0]       pio_wdata_q;
  logic              evt_valid_q;
  logic [DATA_W-1:0] evt_edges_q;
  logic [DATA_W-1:0] evt_level_q;
  logic [TS_W-1:0]   evt_ts_q;

  logic              tick_w;
  logic [DATA_W-1:0] rd_w;
  logic [31:0]       cap_ext_w;

  assign tick_w = enable_i && (timer_q == '0);
  assign rd_w   = bus.pio_readdata[DATA_W-1:0];

  always_comb begin
    cap_ext_w               = '0;
    cap_ext_w[DATA_W-1:0]   = cap_q;
  end

  // Timestamp runs unconditionally; the poll timer only counts while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q    <= '0;
      timer_q <= TMR_RELOAD;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (!enable_i || tick_w) begin
        timer_q <= TMR_RELOAD;
      end else begin
        timer_q <= timer_q - TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      missed_q    <= '0;
      cap_q       <= '0;
      lvl_q       <= '0;
      ts_cap_q    <= '0;
      pio_addr_q  <= ADDR_LEVEL;
      pio_cs_q    <= 1'b0;
      pio_wr_n_q  <= 1'b1;
      pio_wdata_q <= '0;
      evt_valid_q <= 1'b0;
      evt_edges_q <= '0;
      evt_level_q <= '0;
      evt_ts_q    <= '0;
    end else begin
      // Bus returns to idle unless the next state drives a cycle.
      pio_addr_q  <= ADDR_LEVEL;
      pio_cs_q    <= 1'b0;
      pio_wr_n_q  <= 1'b1;
      pio_wdata_q <= '0;

      if (tick_w && (state_q != S_IDLE) && (missed_q != 16'hFFFF)) begin
        missed_q <= missed_q + 16'd1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (tick_w) begin
            state_q    <= S_RD_CAP;
            busy_q     <= 1'b1;
            pio_addr_q <= ADDR_EDGE;
            pio_cs_q   <= 1'b1;
          end
        end
        S_RD_CAP: begin
          state_q <= S_CAP_WAIT;
        end
        S_CAP_WAIT: begin
          cap_q    <= rd_w;
          ts_cap_q <= ts_q;
          if (rd_w == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q    <= S_RD_LVL;
            pio_addr_q <= ADDR_LEVEL;
            pio_cs_q   <= 1'b1;
          end
        end
        S_RD_LVL: begin
          state_q <= S_LVL_WAIT;
        end
        S_LVL_WAIT: begin
          // Write-1-to-clear only the bits we captured; later edges stay pending.
          lvl_q       <= rd_w;
          state_q     <= S_CLR;
          pio_addr_q  <= ADDR_EDGE;
          pio_cs_q    <= 1'b1;
          pio_wr_n_q  <= 1'b0;
          pio_wdata_q <= cap_ext_w;
        end
        S_CLR: begin
          state_q     <= S_EMIT;
          evt_valid_q <= 1'b1;
          evt_edges_q <= cap_q;
          evt_level_q <= lvl_q;
          evt_ts_q    <= ts_cap_q;
        end
        S_EMIT: begin
          if (bus.evt_ready) begin
            evt_valid_q <= 1'b0;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pio_address    = pio_addr_q;
  assign bus.pio_chipselect = pio_cs_q;
  assign bus.pio_write_n    = pio_wr_n_q;
  assign bus.pio_writedata  = pio_wdata_q;
  assign bus.evt_valid      = evt_valid_q;
  assign bus.evt_edges      = evt_edges_q;
  assign bus.evt_level      = evt_level_q;
  assign bus.evt_timestamp  = evt_ts_q;
  assign busy_o             = busy_q;
  assign missed_polls_o     = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_pio_edge_poller.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_pio_edge_poller : directed + random bench with edge-capture PIO and event model
// Rev 1.0
// ============================================================================
module tb_pio_edge_poller;
  localparam int DATA_W      = 8;
  localparam int POLL_PERIOD = 16;
  localparam int TS_W        = 10;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic        ready   = 1'b1;
  logic        busy;
  logic [15:0] missed;

  int n_tests = 0;
  int n_fail  = 0;

  pio_edge_poller_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  pio_edge_poller #(.DATA_W(DATA_W), .POLL_PERIOD(POLL_PERIOD), .TS_W(TS_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_i       (enable),
    .bus            (bus),
    .busy_o         (busy),
    .missed_polls_o (missed)
  );

  always #5 clk = ~clk;

  // Edge-capturing PIO slave: any transition sets a sticky bit, W1C at address 3.
  logic [DATA_W-1:0] in_port = '0;
  logic [DATA_W-1:0] in_prev = '0;
  logic [DATA_W-1:0] cap_reg = '0;
  logic [31:0]       rdata   = '0;
  assign bus.pio_readdata = rdata;
  assign bus.evt_ready    = ready;

  always @(posedge clk) begin
    logic [31:0]       junk;
    logic [DATA_W-1:0] nxt;
    junk = $urandom();
    nxt  = cap_reg;
    if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == 2'd3)
      nxt = nxt & ~bus.pio_writedata[DATA_W-1:0];
    cap_reg <= nxt | (in_port ^ in_prev);
    in_prev <= in_port;
    if (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd0)
      rdata <= {junk[31:DATA_W], in_port};
    else if (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd3)
      rdata <= {junk[31:DATA_W], cap_reg};
    else
      rdata <= junk;
  end

  // Reference model: a poll is a numbered sequence of cycles after its tick.
  int unsigned       m_cyc = 0;
  int                m_k = 0, m_off = 0, m_missed = 0;
  logic [DATA_W-1:0] m_cap = '0, m_lvl = '0, m_e_edges = '0, m_e_level = '0;
  logic [TS_W-1:0]   m_tscap = '0, m_e_ts = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc = 0; m_k = 0; m_off = 0; m_missed = 0;
      m_cap = '0; m_lvl = '0; m_tscap = '0;
      m_e_edges = '0; m_e_level = '0; m_e_ts = '0;
    end else begin
      bit tick;
      tick = enable && ((m_k % POLL_PERIOD) == POLL_PERIOD - 1);
      if (tick && m_off != 0 && m_missed < 65535) m_missed++;
      if (m_off == 0) begin
        if (tick) m_off = 1;
      end else if (m_off == 1) begin
        m_cap = cap_reg; m_off = 2;
      end else if (m_off == 2) begin
        m_tscap = m_cyc[TS_W-1:0];
        m_off   = (m_cap == '0) ? 0 : 3;
      end else if (m_off == 3) begin
        m_lvl = in_port; m_off = 4;
      end else if (m_off < 6) begin
        if (m_off == 5) begin
          m_e_edges = m_cap; m_e_level = m_lvl; m_e_ts = m_tscap;
        end
        m_off++;
      end else if (ready) begin
        m_off = 0;
      end
      m_k = enable ? m_k + 1 : 0;
      m_cyc++;
    end
  end

  logic        exp_cs, exp_wn, exp_busy, exp_valid;
  logic [1:0]  exp_addr;
  logic [31:0] exp_wd;
  assign exp_cs    = (m_off == 1) || (m_off == 3) || (m_off == 5);
  assign exp_addr  = ((m_off == 1) || (m_off == 5)) ? 2'd3 : 2'd0;
  assign exp_wn    = (m_off != 5);
  assign exp_wd    = (m_off == 5) ? {{(32-DATA_W){1'b0}}, m_cap} : 32'd0;
  assign exp_busy  = (m_off != 0);
  assign exp_valid = (m_off == 6);

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_bus got cs=%b wn=%b a=%0d wd=%h exp cs=0 wn=1 a=0 wd=0",
                         bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata);
    end
    n_tests++;
    if ({bus.evt_valid, bus.evt_edges, bus.evt_level, bus.evt_timestamp} !== '0) begin
      n_fail++; $display("FAIL reset_evt got v=%b e=%h l=%h ts=%h exp all 0",
                         bus.evt_valid, bus.evt_edges, bus.evt_level, bus.evt_timestamp);
    end
    n_tests++;
    if ({busy, missed} !== 17'd0) begin
      n_fail++; $display("FAIL reset_status got busy=%b missed=%0d exp 0 0", busy, missed);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_polls();
    int first = -1, last = -1, reads = 0;
    enable = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata, busy} !==
          {exp_cs, exp_wn, exp_addr, exp_wd, exp_busy}) begin
        n_fail++; $display("FAIL idle_bus cyc%0d got cs=%b a=%0d busy=%b exp cs=%b a=%0d busy=%b",
                           i, bus.pio_chipselect, bus.pio_address, busy, exp_cs, exp_addr, exp_busy);
      end
      if (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd3) begin
        if (first < 0) first = i;
        else begin
          n_tests++;
          if (i - last != POLL_PERIOD) begin
            n_fail++; $display("FAIL poll_spacing got %0d exp %0d", i - last, POLL_PERIOD);
          end
        end
        last = i; reads++;
      end
      n_tests++;
      if (bus.evt_valid !== 1'b0 || missed !== 16'd0) begin
        n_fail++; $display("FAIL idle_no_event got v=%b missed=%0d exp 0 0", bus.evt_valid, missed);
      end
    end
    n_tests++;
    if (first != POLL_PERIOD || reads != 5) begin
      n_fail++; $display("FAIL idle_first_read got first=%0d reads=%0d exp %0d 5", first, reads, POLL_PERIOD);
    end
  endtask

  task automatic test_edges();
    int rdcap = -1; logic got = 1'b0; logic [31:0] wr_data = '0; logic [1:0] wr_addr = '0;
    in_port = in_port ^ 8'h24;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd3) rdcap = int'(m_cyc);
      if (bus.pio_chipselect && !bus.pio_write_n) begin wr_data = bus.pio_writedata; wr_addr = bus.pio_address; end
      got = bus.evt_valid;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL edges_timeout got no evt_valid exp evt_valid"); end
    n_tests++;
    if ({wr_addr, wr_data} !== {2'd3, 32'h24}) begin
      n_fail++; $display("FAIL edges_clear got a=%0d wd=%h exp a=3 wd=24", wr_addr, wr_data);
    end
    n_tests++;
    if ({bus.evt_edges, bus.evt_level} !== {8'h24, 8'h24}) begin
      n_fail++; $display("FAIL edges_payload got e=%h l=%h exp 24 24", bus.evt_edges, bus.evt_level);
    end
    n_tests++;
    if (bus.evt_timestamp !== TS_W'(rdcap + 1)) begin
      n_fail++; $display("FAIL edges_ts got %0d exp %0d", bus.evt_timestamp, TS_W'(rdcap + 1));
    end
    @(negedge clk);
    n_tests++;
    if (bus.evt_valid !== 1'b0 || cap_reg !== '0) begin
      n_fail++; $display("FAIL edges_after got v=%b cap=%h exp 0 0", bus.evt_valid, cap_reg);
    end
  endtask

  task automatic test_late_edge();
    logic hit = 1'b0; logic got = 1'b0; logic [31:0] wr_data = '0;
    in_port = in_port ^ 8'h01;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd0;
    end
    @(negedge clk);
    in_port = in_port ^ 8'h80;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.pio_chipselect && !bus.pio_write_n) wr_data = bus.pio_writedata;
      got = bus.evt_valid;
    end
    n_tests++;
    if (!hit || !got || {wr_data, bus.evt_edges, bus.evt_level} !== {32'h01, 8'h01, 8'h25}) begin
      n_fail++; $display("FAIL late_first got hit=%b v=%b wd=%h e=%h l=%h exp 1 1 01 01 25",
                         hit, got, wr_data, bus.evt_edges, bus.evt_level);
    end
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = bus.evt_valid; end
    n_tests++;
    if (!got || bus.evt_edges !== 8'h80) begin
      n_fail++; $display("FAIL late_second got v=%b e=%h exp 1 80", got, bus.evt_edges);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic got = 1'b0; logic [2*DATA_W+TS_W-1:0] pay;
    ready = 1'b0;
    in_port = in_port ^ 8'h08;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = bus.evt_valid; end
    pay = {bus.evt_edges, bus.evt_level, bus.evt_timestamp};
    n_tests++;
    if (!got || bus.evt_edges !== 8'h08) begin
      n_fail++; $display("FAIL stall_first got v=%b e=%h exp 1 08", got, bus.evt_edges);
    end
    for (int j = 0; j < 50; j++) begin
      if (j == 10) in_port = in_port ^ 8'h10;
      @(negedge clk);
      n_tests++;
      if (bus.evt_valid !== 1'b1 || {bus.evt_edges, bus.evt_level, bus.evt_timestamp} !== pay) begin
        n_fail++; $display("FAIL stall_hold cyc%0d got v=%b pay=%h exp 1 %h", j, bus.evt_valid,
                           {bus.evt_edges, bus.evt_level, bus.evt_timestamp}, pay);
      end
    end
    n_tests++;
    if (missed !== m_missed[15:0] || missed < 16'd3) begin
      n_fail++; $display("FAIL stall_missed got %0d exp %0d", missed, m_missed);
    end
    ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL stall_accept got v=%b exp 0", bus.evt_valid); end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = bus.evt_valid; end
    n_tests++;
    if (!got || {bus.evt_edges, bus.evt_level} !== {8'h10, 8'hBD}) begin
      n_fail++; $display("FAIL stall_next got v=%b e=%h l=%h exp 1 10 bd", got, bus.evt_edges, bus.evt_level);
    end
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    logic hit = 1'b0; logic got = 1'b0; int reads = 0; int first = -1;
    in_port = in_port ^ 8'h02;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd0;
    end
    enable = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus.evt_valid; end
    n_tests++;
    if (!hit || !got || bus.evt_edges !== 8'h02) begin
      n_fail++; $display("FAIL endrop_finish got hit=%b v=%b e=%h exp 1 1 02", hit, got, bus.evt_edges);
    end
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.pio_chipselect || busy) reads++;
    end
    n_tests++;
    if (reads != 0) begin n_fail++; $display("FAIL endrop_quiet got %0d active cycles exp 0", reads); end
    enable = 1'b1;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      @(negedge clk);
      if (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd3) first = i;
    end
    n_tests++;
    if (first != POLL_PERIOD) begin
      n_fail++; $display("FAIL endrop_reenable got %0d exp %0d", first, POLL_PERIOD);
    end
  endtask

  task automatic test_reset_mid();
    logic hit = 1'b0;
    in_port = in_port ^ 8'h40;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = bus.pio_chipselect && !bus.pio_write_n;
    end
    n_tests++;
    if (!hit || bus.pio_writedata !== 32'h40) begin
      n_fail++; $display("FAIL rstmid_clr got hit=%b wd=%h exp 1 40", hit, bus.pio_writedata);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      n_fail++; $display("FAIL rstmid_bus got cs=%b wn=%b a=%0d wd=%h exp 0 1 0 0",
                         bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata);
    end
    n_tests++;
    if ({bus.evt_valid, bus.evt_edges, bus.evt_level, bus.evt_timestamp, busy, missed} !== '0) begin
      n_fail++; $display("FAIL rstmid_out got v=%b e=%h busy=%b missed=%0d exp all 0",
                         bus.evt_valid, bus.evt_edges, busy, missed);
    end
    @(negedge clk);
    n_tests++;
    if (cap_reg !== 8'h40) begin n_fail++; $display("FAIL rstmid_pio got cap=%h exp 40", cap_reg); end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata} !==
          {exp_cs, exp_wn, exp_addr, exp_wd}) begin
        n_fail++; $display("FAIL rand_bus cyc%0d got %h exp %h", c,
                           {bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata},
                           {exp_cs, exp_wn, exp_addr, exp_wd});
      end
      n_tests++;
      if ({bus.evt_valid, bus.evt_edges, bus.evt_level, bus.evt_timestamp} !==
          {exp_valid, m_e_edges, m_e_level, m_e_ts}) begin
        n_fail++; $display("FAIL rand_evt cyc%0d got v=%b e=%h l=%h ts=%0d exp v=%b e=%h l=%h ts=%0d", c,
                           bus.evt_valid, bus.evt_edges, bus.evt_level, bus.evt_timestamp,
                           exp_valid, m_e_edges, m_e_level, m_e_ts);
      end
      n_tests++;
      if ({busy, missed} !== {exp_busy, m_missed[15:0]}) begin
        n_fail++; $display("FAIL rand_status cyc%0d got busy=%b missed=%0d exp %b %0d", c,
                           busy, missed, exp_busy, m_missed);
      end
      if ($urandom_range(99) == 0) enable = ~enable;
      if ($urandom_range(7) == 0) in_port = in_port ^ DATA_W'(1 << $urandom_range(DATA_W - 1));
      ready = ($urandom_range(3) != 0);
    end
    ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle_polls();
    test_edges();
    test_late_edge();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish exp finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
